// File: rtl/comparator_pkg.sv
// Shared constants for the three-sensor event comparator: sensor bit positions,
// parameter defaults and a 3-bit population count used by the voter.
package comparator_pkg;
  localparam int N_SENS          = 3;
  localparam int IDX_T           = 2;
  localparam int IDX_S           = 1;
  localparam int IDX_H           = 0;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_FAULT_LIMIT = 3;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/sensor_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous sensor level.
module sensor_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/comparator.sv
// Fault-tolerant 2-of-3 event voter: synchronizes three sensor levels, votes over the
// sensors not yet declared faulty, flags dissenters and retires repeat offenders.
module comparator
  import comparator_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int FAULT_LIMIT = DEF_FAULT_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Temperature,
  input  logic       Smoke,
  input  logic       Humidity,
  input  logic       clear_faults,
  output logic       Output,
  output logic [2:0] Flag,
  output logic       event_pulse,
  output logic [2:0] faulty
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FAULT_LIMIT);

  logic [2:0] sens_raw, s;
  logic [2:0] active, s_act, flag_d, flag_q, flag_rise, faulty_d, faulty_q;
  logic [1:0] n_act, n_hi;
  logic       m, split, out_d, out_q, pulse_d, pulse_q;
  logic [N_SENS-1:0][CNT_W-1:0] cnt_d, cnt_q;

  assign sens_raw = {Temperature, Smoke, Humidity};

  for (genvar i = 0; i < N_SENS; i++) begin : g_sync
    sensor_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sens_raw[i]),
      .q    (s[i])
    );
  end

  // With two active sensors that disagree there is no majority to blame anyone against.
  always_comb begin
    active = ~faulty_q;
    s_act  = s & active;
    n_act  = popcnt3(active);
    n_hi   = popcnt3(s_act);
    split  = (n_act == 2'd2) && (n_hi == 2'd1);
    m      = 1'b0;
    case (n_act)
      2'd3:    m = (n_hi >= 2'd2);
      2'd2:    m = (n_hi == 2'd2);
      default: m = 1'b0;
    endcase
    if (split || (&s) || !(|s)) flag_d = '0;
    else                        flag_d = (s ^ {3{m}}) & active;
    flag_rise = flag_d & ~flag_q;
    out_d     = m;
    pulse_d   = m & ~out_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    faulty_d = faulty_q;
    for (int i = 0; i < N_SENS; i++) begin
      if (flag_rise[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (cnt_q[i] >= LIMIT) faulty_d[i] = 1'b1;
    end
    if (clear_faults) begin
      cnt_d    = '0;
      faulty_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 1'b0;
      pulse_q  <= 1'b0;
      flag_q   <= '0;
      cnt_q    <= '0;
      faulty_q <= '0;
    end else begin
      out_q    <= out_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      faulty_q <= faulty_d;
    end
  end

  assign Output      = out_q;
  assign Flag        = flag_q;
  assign event_pulse = pulse_q;
  assign faulty      = faulty_q;
endmodule

// File: tb/tb_comparator.sv
// Directed-vector bench for the comparator: voting, flags, fault retirement, clear and reset.
module tb_comparator;
  import comparator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_in, s_in, h_in, clear_faults;
  logic       out;
  logic [2:0] flag, faulty;
  logic       pulse;
  int         n_chk = 0;
  int         n_err = 0;

  comparator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Temperature (t_in),
    .Smoke       (s_in),
    .Humidity    (h_in),
    .clear_faults(clear_faults),
    .Output      (out),
    .Flag        (flag),
    .event_pulse (pulse),
    .faulty      (faulty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [2:0] v);
    {t_in, s_in, h_in} = v;
  endtask

  task automatic t_episode();
    set_s(3'b100); tick(4);
    set_s(3'b000); tick(4);
  endtask

  int out_hi, pulses, flag_hits;
  logic [2:0] flag_or;

  initial begin
    rst_n = 1'b0; clear_faults = 1'b0; set_s(3'b000);
    #1;
    chk("rst_out", out, 0);
    chk("rst_flag", flag, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_faulty", faulty, 0);
    tick(2);
    rst_n = 1'b1;

    // idle after release: no pulse
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(1); pulses += int'(pulse); end
    chk("idle_pulses", pulses, 0);
    chk("idle_out", out, 0);

    // all three assert for 20 cycles
    set_s(3'b111);
    tick(2);
    chk("lat_out_early", out, 0);
    tick(1);
    chk("lat_out", out, 1);
    chk("lat_pulse", pulse, 1);
    out_hi = 1; pulses = 1; flag_or = flag;
    for (int i = 3; i < 20; i++) begin
      tick(1); out_hi += int'(out); pulses += int'(pulse); flag_or |= flag;
    end
    set_s(3'b000);
    for (int i = 0; i < 5; i++) begin
      tick(1); out_hi += int'(out); pulses += int'(pulse); flag_or |= flag;
    end
    chk("all_out_cycles", out_hi, 20);
    chk("all_pulses", pulses, 1);
    chk("all_flag", flag_or, 0);

    // smoke alone for 20 cycles
    set_s(3'b010);
    out_hi = 0; pulses = 0; flag_hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1); out_hi += int'(out); pulses += int'(pulse); flag_hits += int'(flag == 3'b010);
    end
    set_s(3'b000);
    for (int i = 0; i < 5; i++) begin
      tick(1); out_hi += int'(out); pulses += int'(pulse); flag_hits += int'(flag == 3'b010);
    end
    chk("smoke_out", out_hi, 0);
    chk("smoke_pulses", pulses, 0);
    chk("smoke_flag_cycles", flag_hits, 20);
    chk("smoke_cnt", dut.cnt_q[IDX_S], 1);
    chk("smoke_cnt_t", dut.cnt_q[IDX_T], 0);

    // T+H against S
    set_s(3'b101);
    tick(3);
    chk("th_out", out, 1);
    chk("th_flag", flag, 3'b010);
    chk("th_pulse", pulse, 1);
    chk("th_cnt_s", dut.cnt_q[IDX_S], 2);
    set_s(3'b000);
    tick(3);
    chk("th_off_out", out, 0);
    chk("th_off_flag", flag, 0);

    clear_faults = 1'b1; tick(1); clear_faults = 1'b0;
    chk("clr_cnt_s", dut.cnt_q[IDX_S], 0);

    // three temperature episodes retire the temperature sensor
    for (int k = 0; k < 3; k++) t_episode();
    chk("t_faulty", faulty, 3'b100);
    chk("t_cnt", dut.cnt_q[IDX_T], 3);
    set_s(3'b011);
    tick(3);
    chk("sh_out", out, 1);
    chk("sh_flag", flag, 0);
    set_s(3'b110);
    tick(3);
    chk("ts_out", out, 0);
    chk("ts_flag", flag, 0);
    set_s(3'b000);
    tick(3);

    // clear coinciding with a temperature disagreement edge
    clear_faults = 1'b1; tick(1); clear_faults = 1'b0;
    chk("clr_faulty", faulty, 0);
    t_episode();
    chk("ep_cnt_t", dut.cnt_q[IDX_T], 1);
    set_s(3'b100);
    tick(2);
    clear_faults = 1'b1;
    tick(1);
    clear_faults = 1'b0;
    chk("clr_race_flag", flag, 3'b100);
    chk("clr_race_cnt", dut.cnt_q[IDX_T], 0);
    chk("clr_race_faulty", faulty, 0);
    tick(2);
    chk("clr_race_cnt_hold", dut.cnt_q[IDX_T], 0);
    set_s(3'b000);
    tick(4);

    // reset mid-event with temperature retired
    for (int k = 0; k < 3; k++) t_episode();
    set_s(3'b111);
    tick(4);
    chk("pre_rst_out", out, 1);
    chk("pre_rst_faulty", faulty, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_flag", flag, 0);
    chk("arst_faulty", faulty, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("rel_out_early", out, 0);
    chk("rel_pulse_early", pulse, 0);
    tick(1);
    chk("rel_out", out, 1);
    chk("rel_pulse", pulse, 1);
    tick(1);
    chk("rel_pulse_once", pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
